// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch sequencer: opcodes, reset PC and FSM states.
package instr_fetch_ctrl_pkg;

    localparam logic [4:0]  OP_HALT          = 5'b00000;
    localparam logic [15:0] NOP_INSTR        = 16'h0800;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int          OPC_HI           = 15;
    localparam int          OPC_LO           = 11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_pc_reg.sv
// 16-bit enabled register with asynchronous reset to a parameterised value.
module instr_fetch_ctrl_pc_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction-memory read port and
// feeds decode through a single-entry output register, flushing on redirect.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] next_pc,
    input  logic        redirect,
    input  logic        id_stall,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [15:0] instr,
    output logic [15:0] pc_inc,
    output logic        instr_valid,
    output logic        halted
);

    fetch_state_t state, state_nxt;
    logic [15:0]  pc_q, req_q, pc_d, cap_addr;
    logic         pc_en, req_en, cap, vld_clr;
    logic         space, consumed;

    assign space    = !instr_valid || !id_stall;
    assign consumed = instr_valid && !id_stall;

    instr_fetch_ctrl_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc_q)
    );

    instr_fetch_ctrl_pc_reg #(.RESET_VAL(RESET_PC)) u_req (
        .clk(clk), .rst(rst), .en(req_en), .d(pc_q), .q(req_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = pc_q;
        pc_en     = 1'b0;
        pc_d      = next_pc;
        req_en    = 1'b0;
        cap       = 1'b0;
        cap_addr  = pc_q;
        vld_clr   = 1'b0;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    pc_en   = 1'b1;
                    vld_clr = 1'b1;
                end else begin
                    if (space) begin
                        mem_rd = 1'b1;
                        if (mem_done) cap = 1'b1;
                        else begin
                            req_en    = 1'b1;
                            state_nxt = S_WAIT;
                        end
                    end
                    if (consumed && !cap) vld_clr = 1'b1;
                end
            end
            S_WAIT: begin
                mem_rd   = 1'b1;
                mem_addr = req_q;
                cap_addr = req_q;
                if (redirect) begin
                    pc_en     = 1'b1;
                    state_nxt = mem_done ? S_FETCH : S_DROP;
                end else if (mem_done) begin
                    cap = 1'b1;
                end
            end
            S_DROP: begin
                // Wrong-path read must still complete before the port is reused.
                mem_rd   = 1'b1;
                mem_addr = req_q;
                if (redirect) pc_en = 1'b1;
                if (mem_done) state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (redirect) begin
                    pc_en     = 1'b1;
                    vld_clr   = 1'b1;
                    state_nxt = S_FETCH;
                end else if (consumed) begin
                    vld_clr = 1'b1;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
        if (cap) begin
            pc_en     = 1'b1;
            pc_d      = cap_addr + 16'd2;
            state_nxt = is_halt(mem_data_out) ? S_HALT : S_FETCH;
        end
        // Reset abandons any outstanding read at once, not at the next edge.
        if (rst) mem_rd = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= NOP_INSTR;
            pc_inc      <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (cap) begin
            instr       <= mem_data_out;
            pc_inc      <= pc_d;
            instr_valid <= 1'b1;
        end else if (vld_clr) begin
            instr_valid <= 1'b0;
        end
    end

    assign halted = (state == S_HALT) && !instr_valid;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a latency-programmable memory model
// and a delivery scoreboard checked by an independent monitor.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] next_pc;
    logic        redirect;
    logic        id_stall;
    logic [15:0] mem_data_out;
    logic        mem_done;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        instr_valid;
    logic        halted;

    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
        .id_stall(id_stall), .mem_data_out(mem_data_out), .mem_done(mem_done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .instr(instr), .pc_inc(pc_inc),
        .instr_valid(instr_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        halt_en  = 1'b0;
    logic [15:0] lat_addr = 16'hFFFF;
    int          lat_n    = 0;
    int          wait_cnt;

    // Memory: word at address a is 0x1000 + a/2, except a HALT at 0x0008 when enabled.
    assign mem_data_out = (halt_en && mem_addr == 16'h0008) ? 16'h0000 : 16'h1000 + (mem_addr >> 1);
    assign mem_done     = mem_rd && (mem_addr != lat_addr || wait_cnt >= lat_n);

    always @(posedge clk or posedge rst) begin
        if (rst)                    wait_cnt <= 0;
        else if (mem_rd && !mem_done) wait_cnt <= wait_cnt + 1;
        else                        wait_cnt <= 0;
    end

    function automatic logic [15:0] word(input logic [15:0] a);
        if (halt_en && a == 16'h0008) return 16'h0000;
        return 16'h1000 + (a >> 1);
    endfunction

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
    } deliv_t;

    deliv_t exp_q[$];
    deliv_t mon_e;
    logic [15:0] exp_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [15:0] a);
        deliv_t e;
        e.instr  = word(a);
        e.pc_inc = a + 16'd2;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && instr_valid && !id_stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery instr=%h pc_inc=%h at %0t", instr, pc_inc, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("deliv_instr", instr, mon_e.instr);
                chk("deliv_pc_inc", pc_inc, mon_e.pc_inc);
            end
        end
    end

    // Releases decode until k instructions from exp_a are consumed, then stalls again.
    task automatic run(input int k);
        int got;
        for (int i = 0; i < k; i++) push(exp_a + 16'(2 * i));
        exp_a    = exp_a + 16'(2 * k);
        got      = 0;
        id_stall = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (instr_valid && !id_stall) got++;
            cyc();
            if (got == k) begin
                id_stall = 1'b1;
                break;
            end
        end
        id_stall = 1'b1;
        chk("run_count", got, k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        redirect = 1'b0;
        next_pc  = 16'h0000;
        id_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_pc_inc", pc_inc, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);

        // Back-to-back hits from reset
        push(16'h0000); push(16'h0002); push(16'h0004);
        rst = 1'b0;
        @(negedge clk); chk("hit_rd0", mem_rd, 1); chk("hit_addr0", mem_addr, 16'h0000); cyc();
        @(negedge clk); chk("hit_addr1", mem_addr, 16'h0002); chk("hit_vld1", instr_valid, 1); cyc();
        @(negedge clk); chk("hit_addr2", mem_addr, 16'h0004); chk("hit_vld2", instr_valid, 1); cyc();
        @(negedge clk); chk("hit_vld3", instr_valid, 1); cyc();
        id_stall = 1'b1;
        exp_a    = 16'h0006;

        // 3-cycle miss at 0x0010
        lat_addr = 16'h0010;
        lat_n    = 3;
        run(4);
        push(16'h000E); push(16'h0010);
        id_stall = 1'b0;
        held     = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 16'h0010) begin
                held++;
                if (mem_done) begin
                    chk("miss_vld_at_done", instr_valid, 0);
                    cyc();
                    break;
                end
            end
            cyc();
        end
        chk("miss_held_cycles", held, 4);
        @(negedge clk); chk("miss_vld_after", instr_valid, 1); chk("miss_pc_inc", pc_inc, 16'h0012); cyc();
        id_stall = 1'b1;

        // Decode stall holds the output register and the port
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_vld", instr_valid, 1);
            chk("stall_pc_inc", pc_inc, 16'h0014);
            chk("stall_instr", instr, word(16'h0012));
            chk("stall_no_rd", mem_rd, 0);
            cyc();
        end
        push(16'h0012);
        id_stall = 1'b0;
        @(negedge clk); chk("resume_rd", mem_rd, 1); chk("resume_addr", mem_addr, 16'h0014); cyc();
        id_stall = 1'b1;

        // Redirect during a miss: wrong-path read completes, then target fetch
        lat_addr = 16'h0020;
        lat_n    = 3;
        redirect = 1'b1; next_pc = 16'h0020;
        @(negedge clk); cyc();
        redirect = 1'b0;
        @(negedge clk); chk("drop_w0_rd", mem_rd, 1); chk("drop_w0_addr", mem_addr, 16'h0020); cyc();
        redirect = 1'b1; next_pc = 16'h0040;
        @(negedge clk); chk("drop_w1_addr", mem_addr, 16'h0020); chk("drop_w1_done", mem_done, 0); cyc();
        redirect = 1'b0;
        @(negedge clk); chk("drop_w2_addr", mem_addr, 16'h0020); chk("drop_w2_vld", instr_valid, 0); cyc();
        @(negedge clk); chk("drop_w3_addr", mem_addr, 16'h0020); chk("drop_w3_done", mem_done, 1); cyc();
        @(negedge clk);
        chk("drop_next_rd", mem_rd, 1);
        chk("drop_next_addr", mem_addr, 16'h0040);
        chk("drop_discard_vld", instr_valid, 0);
        cyc();

        // HALT fetched at 0x0008, then redirect out of it
        halt_en  = 1'b1;
        redirect = 1'b1; next_pc = 16'h0004;
        @(negedge clk); cyc();
        redirect = 1'b0;
        exp_a    = 16'h0004;
        run(3);
        @(negedge clk); chk("halt_halted", halted, 1); chk("halt_no_rd", mem_rd, 0); chk("halt_vld", instr_valid, 0); cyc();
        @(negedge clk); chk("halt_no_rd2", mem_rd, 0); cyc();
        redirect = 1'b1; next_pc = 16'h0100;
        @(negedge clk); chk("halt_redir_cycle", halted, 1); cyc();
        redirect = 1'b0;
        @(negedge clk); chk("unhalt", halted, 0); chk("unhalt_rd", mem_rd, 1); chk("unhalt_addr", mem_addr, 16'h0100); cyc();

        // PC wrap at 0xFFFE
        redirect = 1'b1; next_pc = 16'hFFFE;
        @(negedge clk); cyc();
        redirect = 1'b0;
        @(negedge clk); chk("wrap_addr", mem_addr, 16'hFFFE); cyc();
        @(negedge clk); chk("wrap_vld", instr_valid, 1); chk("wrap_pc_inc", pc_inc, 16'h0000); cyc();
        push(16'hFFFE);
        id_stall = 1'b0;
        @(negedge clk); chk("wrap_next_rd", mem_rd, 1); chk("wrap_next_addr", mem_addr, 16'h0000); cyc();
        id_stall = 1'b1;

        // Reset in the middle of a miss
        redirect = 1'b1; next_pc = 16'h0020;
        @(negedge clk); cyc();
        redirect = 1'b0;
        @(negedge clk); chk("rstmiss_rd", mem_rd, 1); chk("rstmiss_addr", mem_addr, 16'h0020);
        #1 rst = 1'b1;
        #1 chk("rstmiss_rd_drop", mem_rd, 0); chk("rstmiss_vld", instr_valid, 0); chk("rstmiss_halted", halted, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk); chk("rstmiss_refetch_rd", mem_rd, 1); chk("rstmiss_refetch_addr", mem_addr, 16'h0000); cyc();

        repeat (2) cyc();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch sequencer that consumes the selected next-PC value and drives the instruction-memory read port. It owns the architectural PC register, issues one read per instruction, holds each request until memory completes, and presents the fetched instruction and PC+2 to decode through a single-entry output register. Redirects from execute (taken branch/jump/return) flush wrong-path work, including a memory read already in flight.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- next_pc  in  16  redirect target from execute
- redirect  in  1  one-cycle pulse; load next_pc, flush
- id_stall  in  1  decode cannot accept this cycle
- mem_data_out  in  16  instruction word, valid when mem_done=1
- mem_done  in  1  read complete; may assert in the same cycle as the first mem_rd (hit)
- mem_rd  out  1  read request; held with stable mem_addr until mem_done
- mem_addr  out  16  read address
- instr  out  16  fetched instruction (registered)
- pc_inc  out  16  address of instr + 2 (registered)
- instr_valid  out  1  instr/pc_inc hold a live instruction
- halted  out  1  HALT delivered and consumed; fetch stopped

## Operation
- Registers: pc, req_addr, state, instr, pc_inc, instr_valid.
- Reset values: pc=RESET_PC, state=FETCH, instr=16'h0800 (NOP), pc_inc=16'h0000, instr_valid=0, mem_rd=0, halted=0.
- space = !instr_valid || !id_stall. A consumed output means instr_valid && !id_stall.
- FETCH (nothing outstanding):
  - redirect: pc<=next_pc, instr_valid<=0, no request this cycle.
  - else if space: mem_rd=1, mem_addr=pc (combinational). If mem_done: capture. Otherwise req_addr<=pc and go to WAIT.
  - consumed with no new capture: instr_valid<=0.
- WAIT: mem_rd=1, mem_addr=req_addr. The output register is empty.
  - redirect: pc<=next_pc. If mem_done, discard the data and go to FETCH. Otherwise go to DROP.
  - else if mem_done: capture, then go to FETCH.
- DROP (wrong-path read in flight):
  - mem_rd=1, mem_addr=req_addr.
  - redirect: pc<=next_pc, latest wins.
  - mem_done: discard the data and go to FETCH.
- Capture of address A:
  - instr<=mem_data_out, pc_inc<=A+2, pc<=A+2, instr_valid<=1.
  - If mem_data_out[15:11]==5'b00000 (HALT), go to HALT instead of FETCH.
- HALT:
  - mem_rd=0.
  - instr_valid clears when consumed.
  - halted = (state==HALT) && !instr_valid.
  - redirect: pc<=next_pc, instr_valid<=0, go to FETCH. This covers a wrong-path HALT. halted drops.
- Redirect always beats mem_done and id_stall in the same cycle.
- Arithmetic: A+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000. No alignment check.

## Timing
- Reset is asynchronous. The first mem_rd rises in the first cycle after rst deasserts.
- Hit (mem_done with mem_rd): instr_valid rises at the next edge. Sustained throughput is 1 instruction/cycle with id_stall=0.
- Miss of N cycles: the request is held N+1 cycles, and instr_valid rises the edge after mem_done.
- id_stall=1 with instr_valid=1: instr/pc_inc hold and no request is issued.
- Redirect latency: the first request to the target issues the cycle after redirect if nothing is outstanding. Otherwise it issues the cycle after the dropped read's mem_done.
- rst mid-miss abandons the request. mem_rd drops immediately.

## Structure
- Shared package:
  - OP_HALT=5'b00000, NOP_INSTR=16'h0800, opcode field [15:11].
  - 2-bit state encoding FETCH/WAIT/DROP/HALT.
  - Default RESET_PC.
- Sub-module pc_reg: 16-bit register with enable and async reset to a parameter value. Instantiated for pc and req_addr.

## Test plan
- Reset, hits, id_stall=0, memory returns 0x1000.. at addresses 0,2,4 -> mem_addr 0,2,4 on consecutive cycles; pc_inc 2,4,6; instr_valid continuous.
- 3-cycle miss at pc=0x0010 -> mem_rd/mem_addr=0x0010 held 4 cycles; instr_valid rises the edge after mem_done; pc_inc=0x0012.
- id_stall=1 for 2 cycles with instr_valid=1 -> instr/pc_inc unchanged, mem_rd=0; fetch resumes the cycle id_stall drops.
- redirect to 0x0040 during a miss at 0x0020 -> mem_addr stays 0x0020 until mem_done, data discarded, instr_valid stays 0; next mem_addr=0x0040.
- HALT word (0x0000) fetched at 0x0008 -> no further mem_rd; halted=1 after consumption. redirect to 0x0100 -> halted=0, fetch at 0x0100.
- Fetch at 0xFFFE (hit) -> pc_inc=0x0000, next mem_addr=0x0000.
